// File: rtl/bus_arb_pkg.sv
// Shared definitions for the 4-requester packet bus arbiter.
//   NUM_REQ / DATA_W : requester count and data width
//   state_t          : arbiter FSM states
//   rr_pick()        : round-robin winner, searching from last+1 and wrapping
package bus_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Returns the first valid requester after 'last', wrapping 3->0.
  // 'last' itself is checked at the end of the search. If nothing is
  // valid, 'last' is returned unchanged.
  function automatic logic [1:0] rr_pick(input logic [1:0]         last,
                                         input logic [NUM_REQ-1:0] valid);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = last + 2'(i);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/Mux4_to_1_32bit.sv
// 4-to-1 data multiplexer (legacy name; width set by WIDTH, 8 bits here).
//   in0..in3 : data inputs
//   sel      : input select
//   out      : selected input
module Mux4_to_1_32bit
  import bus_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
    endcase
  end

endmodule

// File: rtl/bus_arb4.sv
// Round-robin arbiter granting one of four packet sources to a shared bus.
// A grant lasts until the packet's last beat or until MAX_BEATS beats have
// transferred, whichever comes first; a cut packet resumes on a later grant.
//   clk, rst            : clock (rising edge), async active-high reset
//   req_valid/req_last  : per-requester beat valid / final beat
//   req_data0..3        : per-requester data
//   req_ready           : per-requester beat accepted (granted source only)
//   out_valid/data/last : shared-bus beat, zero while idle
//   out_src             : granted requester (last grant while idle)
//   out_ready           : downstream accepts the beat
module bus_arb4
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_last,
  input  logic [DATA_W-1:0]  req_data0,
  input  logic [DATA_W-1:0]  req_data1,
  input  logic [DATA_W-1:0]  req_data2,
  input  logic [DATA_W-1:0]  req_data3,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last,
  output logic [1:0]         out_src,
  input  logic               out_ready
);

  localparam logic [7:0] BEAT_LIMIT = 8'(MAX_BEATS);

  state_t            state;
  logic [1:0]        grant;     // current grant while BUSY, last grant while IDLE
  logic [7:0]        beat_cnt;
  logic [DATA_W-1:0] mux_data;
  logic              busy;
  logic              xfer;
  logic              release_now;

  Mux4_to_1_32bit #(
    .WIDTH(DATA_W)
  ) u_mux (
    .in0(req_data0),
    .in1(req_data1),
    .in2(req_data2),
    .in3(req_data3),
    .sel(grant),
    .out(mux_data)
  );

  always_comb begin
    busy      = (state == BUSY);
    out_valid = busy && req_valid[grant];
    out_last  = busy && req_last[grant];
    out_data  = busy ? mux_data : '0;
    out_src   = grant;
    req_ready = '0;
    if (busy && out_ready) begin
      req_ready[grant] = 1'b1;
    end
    xfer = out_valid && out_ready;
    // Last beat and beat limit share one release condition, so a packet
    // ending exactly on the limit releases once.
    release_now = xfer && (out_last || (beat_cnt + 8'd1 == BEAT_LIMIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 2'd3;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant    <= rr_pick(grant, req_valid);
            state    <= BUSY;
            beat_cnt <= '0;
          end
        end
        BUSY: begin
          if (release_now) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb4.sv
// Self-checking bench for bus_arb4 (MAX_BEATS=4): per-cycle comparison
// against a behavioural arbiter model, plus directed packet scenarios with
// hand-computed transfer sequences.
module tb_bus_arb4;

  localparam int MAXB = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  typedef struct {
    logic [1:0] s;
    logic [7:0] d;
    int         cyc;
  } xfer_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [3:0] req_last  = '0;
  logic [7:0] dat [4] = '{default: '0};
  logic       out_ready = 1'b1;
  logic [3:0] req_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic [1:0] out_src;

  beat_t q [4][$];
  xfer_t xlog[$];
  logic [3:0] acc = '0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy2_cnt = 0;

  // model state
  logic m_busy = 1'b0;
  int   m_g    = 3;
  int   m_cnt  = 0;

  bus_arb4 #(.MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last),
    .req_data0(dat[0]), .req_data1(dat[1]), .req_data2(dat[2]), .req_data3(dat[3]),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: idle/busy, grant owner, beats taken in this grant.
  always @(posedge clk or posedge rst) begin
    int pick;
    if (rst) begin
      m_busy <= 1'b0;
      m_g    <= 3;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      pick = -1;
      for (int k = 1; k <= 4; k++)
        if (pick < 0 && req_valid[(m_g + k) % 4]) pick = (m_g + k) % 4;
      if (pick >= 0) begin
        m_g    <= pick;
        m_busy <= 1'b1;
        m_cnt  <= 0;
      end
    end else if (req_valid[m_g] && out_ready) begin
      if (req_last[m_g] || m_cnt + 1 == MAXB) begin
        m_busy <= 1'b0;
        m_cnt  <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Compare process, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    check("out_valid", out_valid, m_busy && req_valid[m_g]);
    check("out_data",  out_data,  m_busy ? dat[m_g] : 8'h00);
    check("out_last",  out_last,  m_busy && req_last[m_g]);
    check("out_src",   out_src,   m_g);
    check("req_ready", req_ready, (m_busy && out_ready) ? (4'b0001 << m_g) : 4'b0000);
    acc = req_valid & req_ready;
    if (req_ready[2]) rdy2_cnt++;
    if (out_valid && out_ready) xlog.push_back('{s: out_src, d: out_data, cyc: cyc});
  end

  // Per-requester sources: pop accepted beat, present queue head.
  always @(posedge clk) begin
    #1;
    for (int r = 0; r < 4; r++) begin
      if (acc[r] && q[r].size() > 0) void'(q[r].pop_front());
      if (q[r].size() > 0) begin
        req_valid[r] = 1'b1;
        dat[r]       = q[r][0].d;
        req_last[r]  = q[r][0].l;
      end else begin
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
      end
    end
  end

  task automatic load(input int r, input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) q[r].push_back('{d: first + 8'(k), l: (k == n - 1)});
  endtask

  task automatic expect_xfer(input string name, input int idx, input logic [1:0] s, input logic [7:0] d);
    if (idx >= xlog.size()) begin
      checks++;
      errors++;
      $display("FAIL %s missing transfer %0d (have %0d)", name, idx, xlog.size());
    end else begin
      check({name, "_src"}, xlog[idx].s, s);
      check({name, "_data"}, xlog[idx].d, d);
    end
  endtask

  task automatic wait_log(input int n);
    int ok;
    ok = 0;
    for (int i = 0; i < 200 && ok == 0; i++) begin
      @(posedge clk); #2;
      if (xlog.size() >= n) ok = 1;
    end
    check("wait_log_timeout", ok, 1);
  endtask

  task automatic wait_drain();
    int ok;
    ok = 0;
    for (int i = 0; i < 300 && ok == 0; i++) begin
      @(posedge clk); #2;
      if (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0) ok = 1;
    end
    check("drain_timeout", ok, 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int b;
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", req_ready, 4'b0000);
    check("rst_data",  out_data,  8'h00);
    check("rst_last",  out_last,  1'b0);
    check("rst_src",   out_src,   2'd3);
    rst = 1'b0;

    // Everyone valid, single-beat packets: 0,1,2,3,0 with an idle cycle between.
    b = xlog.size();
    load(0, 8'hA0, 1);
    q[0].push_back('{d: 8'hA4, l: 1'b1});
    load(1, 8'hB1, 1);
    load(2, 8'hC2, 1);
    load(3, 8'hD3, 1);
    wait_drain();
    expect_xfer("rr0", b + 0, 2'd0, 8'hA0);
    expect_xfer("rr1", b + 1, 2'd1, 8'hB1);
    expect_xfer("rr2", b + 2, 2'd2, 8'hC2);
    expect_xfer("rr3", b + 3, 2'd3, 8'hD3);
    expect_xfer("rr4", b + 4, 2'd0, 8'hA4);
    for (int i = 0; i < 4; i++)
      if (b + i + 1 < xlog.size()) check("rr_gap", xlog[b + i + 1].cyc - xlog[b + i].cyc, 2);

    // Requester 2, three-beat packet.
    b = xlog.size();
    rdy2_cnt = 0;
    load(2, 8'hA1, 3);
    wait_drain();
    expect_xfer("p2_a1", b + 0, 2'd2, 8'hA1);
    expect_xfer("p2_a2", b + 1, 2'd2, 8'hA2);
    expect_xfer("p2_a3", b + 2, 2'd2, 8'hA3);
    check("p2_ready_cycles", rdy2_cnt, 3);

    // Requester 1 six beats, cut at 4; requester 3 served in between.
    b = xlog.size();
    load(1, 8'h11, 6);
    repeat (2) @(posedge clk);
    #2;
    load(3, 8'h31, 1);
    wait_drain();
    expect_xfer("cut0", b + 0, 2'd1, 8'h11);
    expect_xfer("cut1", b + 1, 2'd1, 8'h12);
    expect_xfer("cut2", b + 2, 2'd1, 8'h13);
    expect_xfer("cut3", b + 3, 2'd1, 8'h14);
    expect_xfer("cut4", b + 4, 2'd3, 8'h31);
    expect_xfer("cut5", b + 5, 2'd1, 8'h15);
    expect_xfer("cut6", b + 6, 2'd1, 8'h16);

    // Downstream stall after beat 1 of a 5-beat packet from requester 0.
    b = xlog.size();
    load(0, 8'h01, 5);
    wait_log(b + 1);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_data",  out_data,  8'h02);
      check("stall_valid", out_valid, 1'b1);
      check("stall_ready", req_ready, 4'b0000);
    end
    check("stall_cnt", dut.beat_cnt, 8'd1);
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();
    expect_xfer("st1", b + 0, 2'd0, 8'h01);
    expect_xfer("st2", b + 1, 2'd0, 8'h02);
    expect_xfer("st4", b + 3, 2'd0, 8'h04);
    expect_xfer("st5", b + 4, 2'd0, 8'h05);
    if (b + 4 < xlog.size()) check("st_regrant_gap", xlog[b + 4].cyc - xlog[b + 3].cyc, 2);

    // Last beat coincides with the beat limit, then wrap-around re-grant of 3.
    b = xlog.size();
    load(3, 8'h61, 4);
    wait_drain();
    expect_xfer("lim0", b + 0, 2'd3, 8'h61);
    expect_xfer("lim3", b + 3, 2'd3, 8'h64);
    check("lim_count", xlog.size() - b, 4);
    check("lim_idle_src", out_src, 2'd3);
    b = xlog.size();
    load(3, 8'h6F, 1);
    wait_drain();
    expect_xfer("wrap", b, 2'd3, 8'h6F);

    // Reset mid-packet after beat 2 of 4.
    b = xlog.size();
    load(1, 8'h51, 4);
    repeat (2) @(posedge clk);
    #2;
    load(0, 8'h0A, 1);
    wait_log(b + 2);
    check("pre_rst_valid", out_valid, 1'b1);
    check("pre_rst_data",  out_data,  8'h53);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", req_ready, 4'b0000);
    check("mid_rst_data",  out_data,  8'h00);
    check("mid_rst_last",  out_last,  1'b0);
    check("mid_rst_src",   out_src,   2'd3);
    check("mid_rst_cnt",   dut.beat_cnt, 8'd0);
    @(posedge clk);
    #2;
    check("rst_no_beat3", xlog.size() - b, 2);
    rst = 1'b0;
    wait_drain();
    expect_xfer("post_rst0", b + 2, 2'd0, 8'h0A);
    expect_xfer("post_rst1", b + 3, 2'd1, 8'h53);
    expect_xfer("post_rst2", b + 4, 2'd1, 8'h54);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arb4.md
BUS_ARB4 -- requirements
Module: bus_arb4

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 8, meaning the maximum number of beats accepted per grant before the grant is forcibly released (legal range 1..255).
REQ-002 SHALL have port clk  input  1  meaning the single clock, rising-edge.
REQ-003 SHALL have port rst  input  1  meaning the reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid  input  4  meaning the per-requester beat valid.
REQ-005 SHALL have port req_last  input  4  meaning the per-requester final beat of a packet.
REQ-006 SHALL have port req_data0..req_data3  input  8 each  meaning the per-requester data.
REQ-007 SHALL have port req_ready  output  4  meaning the per-requester beat accepted.
REQ-008 SHALL have port out_valid  output  1  meaning the shared-bus beat valid.
REQ-009 SHALL have port out_data  output  8  meaning the shared-bus data.
REQ-010 SHALL have port out_last  output  1  meaning the shared-bus final beat.
REQ-011 SHALL have port out_src  output  2  meaning the index of the granted requester.
REQ-012 SHALL have port out_ready  input  1  meaning the downstream accepts the beat.

Function
REQ-013 SHALL implement FSM states IDLE and BUSY.
REQ-014 In IDLE, when any req_valid bit is 1, the block SHALL register a grant and enter BUSY on the next edge; arbitration latency is exactly 1 cycle.
REQ-015 Arbitration SHALL be round-robin: priority starts at (last_grant+1) mod 4 and wraps 3->0.
REQ-016 In BUSY, out_valid, out_data and out_last SHALL equal the granted requester's valid, data and last, combinationally through the select = grant.
REQ-017 req_ready[g] SHALL equal (state==BUSY && out_ready); all other req_ready bits SHALL be 0.
REQ-018 A beat SHALL transfer when out_valid && out_ready; each transfer SHALL increment an 8-bit beat counter.
REQ-019 BUSY SHALL return to IDLE, update last_grant to g and clear the beat counter on the edge after a transfer with out_last=1.
REQ-020 The same return to IDLE SHALL occur after the transfer that makes the beat counter equal MAX_BEATS, even if out_last=0; that packet then continues on a later grant.
REQ-021 When out_last and the MAX_BEATS limit occur together, the block SHALL perform a single release with no double update.
REQ-022 In IDLE, out_valid SHALL be 0, req_ready SHALL be 0, out_data SHALL be 8'h00, out_last SHALL be 0 and out_src SHALL hold the last grant.
REQ-023 If the granted requester drops req_valid mid-packet, the block SHALL remain BUSY with out_valid=0 (no preemption).
REQ-024 Back-to-back grants SHALL incur one IDLE cycle between packets.

Reset
REQ-025 On rst=1, asynchronously: state=IDLE, last_grant=2'd3 (requester 0 highest priority first), beat counter=0, all outputs at IDLE values.
REQ-026 If rst asserts mid-packet, the packet SHALL be abandoned and no beat accepted in that cycle.

Structure
REQ-027 Package bus_arb_pkg SHALL hold NUM_REQ=4, DATA_W=8, the state enum and the round-robin pick function.
REQ-028 The data path SHALL instantiate the existing 8-bit 4-to-1 mux Mux4_to_1_32bit with sel=grant; the FSM, counter and ready gating SHALL remain in bus_arb4.

Verification
REQ-029 After reset, with req_valid=4'b1111, all last=1 and out_ready=1, the bench SHALL see grants in the order 0,1,2,3,0, one beat each, with an IDLE cycle between grants.
REQ-030 With requester 2 sending 3 beats A1,A2,A3 (last on A3) and out_ready=1, the bench SHALL see out_data A1,A2,A3, out_src=2, req_ready[2] high for 3 cycles, then IDLE.
REQ-031 With MAX_BEATS=4 and requester 1 sending a 6-beat packet while requester 3 is valid, the bench SHALL see 4 beats from 1, then requester 3, then the remaining 2 beats from 1.
REQ-032 With out_ready=0 for 5 cycles during BUSY, the bench SHALL see out_data stable, req_ready=0 and the beat counter unchanged.
REQ-033 With rst pulsed after beat 2 of 4, the bench SHALL see outputs immediately at IDLE values and the next grant to requester 0 if valid.
REQ-034 With only requester 3 valid and last_grant=3, the bench SHALL see requester 3 re-granted (wrap-around).
